kf8237_transfer_sequencer: RTL and testbench

//  Timing/control stage directly downstream of the 8237 priority encoder. Consumes the one-hot

---
 rtl/kf8237_transfer_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_kf8237_transfer_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/kf8237_transfer_sequencer.sv
// 8237 transfer sequencer: HRQ/HLDA handshake, SI/S0..S4 cycle, DACK/AEN, strobes, next_word and EOP.
// Define KF8237_EXTENDED_WRITE_EN to assert the write strobe in S2 alongside the read strobe.
module kf8237_transfer_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_clock_posedge,
  input  logic       cpu_clock_negedge,
  input  logic       master_clear,
  input  logic [3:0] encoded_dma,
  input  logic [3:0] dma_request_state,
  input  logic [7:0] mode_transfer_type,
  input  logic [3:0] mode_demand,
  input  logic       terminal_count,
  input  logic       end_of_process_n,
  input  logic       hold_acknowledge,
  input  logic       ready,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge_internal,
  output logic       address_enable,
  output logic       memory_read_n,
  output logic       memory_write_n,
  output logic       io_read_n,
  output logic       io_write_n,
  output logic       next_word,
  output logic       end_of_process_internal,
  output logic [1:0] dma_rotate
);

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

`ifdef KF8237_EXTENDED_WRITE_EN
  localparam logic EXT_WRITE = 1'b1;
`else
  localparam logic EXT_WRITE = 1'b0;
`endif

  state_t     state, state_next;
  logic [1:0] ch, ch_next;
  logic       hrq, hrq_next;
  logic [3:0] dack, dack_next;
  logic       aen, aen_next;
  logic [3:0] strb, strb_next;  // {memory_read_n, memory_write_n, io_read_n, io_write_n}
  logic       nw, nw_next;
  logic       eop, eop_next;
  logic [1:0] rot, rot_next;
  logic       eop_latched, eop_latched_next;
  logic       term_pending, term_pending_next;
  logic [1:0] xfer_type;
  logic       eop_seen;

  function automatic logic [3:0] read_mask(input logic [1:0] t);
    case (t)
      2'b01:   read_mask = 4'b0010;
      2'b10:   read_mask = 4'b1000;
      default: read_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] write_mask(input logic [1:0] t);
    case (t)
      2'b01:   write_mask = 4'b0100;
      2'b10:   write_mask = 4'b0001;
      default: write_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] encode(input logic [3:0] oh);
    if (oh[0])      encode = 2'd0;
    else if (oh[1]) encode = 2'd1;
    else if (oh[2]) encode = 2'd2;
    else            encode = 2'd3;
  endfunction

  assign xfer_type = mode_transfer_type[{ch, 1'b0} +: 2];
  assign eop_seen  = ~end_of_process_n | eop_latched;

  always_comb begin
    state_next        = state;
    ch_next           = ch;
    hrq_next          = hrq;
    dack_next         = dack;
    aen_next          = aen;
    strb_next         = strb;
    nw_next           = 1'b0;
    eop_next          = 1'b0;
    rot_next          = rot;
    eop_latched_next  = eop_latched;
    term_pending_next = term_pending;

    // An external EOP seen mid-word is held until the word completes.
    if ((state == S1 || state == S2 || state == S3) && !end_of_process_n)
      eop_latched_next = 1'b1;

    if (cpu_clock_negedge && state == S4)
      strb_next = 4'b1111;

    if (cpu_clock_posedge) begin
      case (state)
        SI: begin
          if (encoded_dma != 4'b0000 && !hold_acknowledge) begin
            ch_next          = encode(encoded_dma);
            hrq_next         = 1'b1;
            eop_latched_next = 1'b0;
            state_next       = S0;
          end
        end
        S0: begin
          if (hold_acknowledge) begin
            aen_next   = 1'b1;
            dack_next  = 4'b0001 << ch;
            state_next = S1;
          end else if (!dma_request_state[ch]) begin
            hrq_next   = 1'b0;
            state_next = SI;
          end
        end
        S1: begin
          strb_next  = strb & ~(read_mask(xfer_type) | (EXT_WRITE ? write_mask(xfer_type) : 4'b0000));
          state_next = S2;
        end
        S2: begin
          strb_next  = strb & ~write_mask(xfer_type);
          state_next = S3;
        end
        S3: begin
          if (ready) begin
            nw_next           = 1'b1;
            eop_next          = terminal_count | eop_seen;
            term_pending_next = terminal_count | eop_seen;
            eop_latched_next  = 1'b0;
            state_next        = S4;
          end
        end
        S4: begin
          if (!term_pending && mode_demand[ch] && dma_request_state[ch]) begin
            strb_next  = 4'b1111 & ~(read_mask(xfer_type) | (EXT_WRITE ? write_mask(xfer_type) : 4'b0000));
            state_next = S2;
          end else begin
            hrq_next          = 1'b0;
            dack_next         = 4'b0000;
            aen_next          = 1'b0;
            strb_next         = 4'b1111;
            rot_next          = ch;
            term_pending_next = 1'b0;
            state_next        = SI;
          end
        end
        default: state_next = SI;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || master_clear) begin
      state        <= SI;
      ch           <= 2'd0;
      hrq          <= 1'b0;
      dack         <= 4'b0000;
      aen          <= 1'b0;
      strb         <= 4'b1111;
      nw           <= 1'b0;
      eop          <= 1'b0;
      rot          <= 2'b11;
      eop_latched  <= 1'b0;
      term_pending <= 1'b0;
    end else begin
      state        <= state_next;
      ch           <= ch_next;
      hrq          <= hrq_next;
      dack         <= dack_next;
      aen          <= aen_next;
      strb         <= strb_next;
      nw           <= nw_next;
      eop          <= eop_next;
      rot          <= rot_next;
      eop_latched  <= eop_latched_next;
      term_pending <= term_pending_next;
    end
  end

  assign hold_request             = hrq;
  assign dma_acknowledge_internal = dack;
  assign address_enable           = aen;
  assign memory_read_n            = strb[3];
  assign memory_write_n           = strb[2];
  assign io_read_n                = strb[1];
  assign io_write_n               = strb[0];
  assign next_word                = nw;
  assign end_of_process_internal  = eop;
  assign dma_rotate               = rot;

endmodule

// File: tb/tb_kf8237_transfer_sequencer.sv
// Randomized bench for kf8237_transfer_sequencer against a per-service transaction model
// (words moved, EOP pulses, strobe-low cycle totals, DACK/AEN, rotate).
module tb_kf8237_transfer_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_clock_posedge = 1'b0;
  logic       cpu_clock_negedge = 1'b0;
  logic       master_clear = 1'b0;
  logic [3:0] encoded_dma = 4'b0000;
  logic [3:0] dma_request_state = 4'b0000;
  logic [7:0] mode_transfer_type = 8'h00;
  logic [3:0] mode_demand = 4'b0000;
  logic       terminal_count = 1'b0;
  logic       end_of_process_n = 1'b1;
  logic       hold_acknowledge = 1'b0;
  logic       ready = 1'b1;
  logic       hold_request;
  logic [3:0] dma_acknowledge_internal;
  logic       address_enable;
  logic       memory_read_n, memory_write_n, io_read_n, io_write_n;
  logic       next_word;
  logic       end_of_process_internal;
  logic [1:0] dma_rotate;

  int n_run  = 0;
  int n_fail = 0;
  int phase  = 0;

  kf8237_transfer_sequencer dut (
    .clock(clock), .reset(reset),
    .cpu_clock_posedge(cpu_clock_posedge), .cpu_clock_negedge(cpu_clock_negedge),
    .master_clear(master_clear), .encoded_dma(encoded_dma),
    .dma_request_state(dma_request_state), .mode_transfer_type(mode_transfer_type),
    .mode_demand(mode_demand), .terminal_count(terminal_count),
    .end_of_process_n(end_of_process_n), .hold_acknowledge(hold_acknowledge),
    .ready(ready), .hold_request(hold_request),
    .dma_acknowledge_internal(dma_acknowledge_internal), .address_enable(address_enable),
    .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
    .io_read_n(io_read_n), .io_write_n(io_write_n), .next_word(next_word),
    .end_of_process_internal(end_of_process_internal), .dma_rotate(dma_rotate)
  );

  initial forever #5 clock = ~clock;

  // CPU clock is four system clocks: rising-edge strobe at phase 0, falling at phase 2.
  initial forever begin
    @(negedge clock);
    phase = (phase + 1) % 4;
    cpu_clock_posedge = (phase == 0);
    cpu_clock_negedge = (phase == 2);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] out_vec();
    return {hold_request, dma_acknowledge_internal, address_enable, memory_read_n,
            memory_write_n, io_read_n, io_write_n, next_word, end_of_process_internal, dma_rotate};
  endfunction

  task automatic apply_clear(input bit use_mc, input string tag);
    @(negedge clock);
    if (use_mc) master_clear = 1'b1; else reset = 1'b1;
    encoded_dma = 4'b0000; hold_acknowledge = 1'b0; ready = 1'b1;
    end_of_process_n = 1'b1; terminal_count = 1'b0;
    @(negedge clock);
    master_clear = 1'b0; reset = 1'b0;
    check(tag, 32'(out_vec()), 32'(14'b0_0000_0_1111_0_0_11));
  endtask

  task automatic run_service(input int ch, input int ty, input bit dem, input int tcw,
                             input int eopw, input int reqw, input int hd, input logic [7:0] wv);
    int nw, eops, cyc, hcyc, w, exp_w, exp_eop, exp_rd, exp_wr, aen_bad, hrq_ign;
    int lo_mr, lo_mw, lo_ir, lo_iw;
    logic [3:0] dack_seen;
    bit started, done;
    nw = 0; eops = 0; cyc = 0; hcyc = 0; aen_bad = 0; hrq_ign = 0;
    lo_mr = 0; lo_mw = 0; lo_ir = 0; lo_iw = 0;
    dack_seen = 4'b0000; started = 1'b0; done = 1'b0;
    mode_transfer_type = 8'($urandom);
    mode_transfer_type[2*ch +: 2] = 2'(ty);
    mode_demand = 4'($urandom);
    mode_demand[ch] = dem;
    dma_request_state = 4'($urandom);
    dma_request_state[ch] = 1'b1;
    encoded_dma = 4'b0001 << ch;
    hold_acknowledge = 1'b0; ready = 1'b1; end_of_process_n = 1'b1;
    terminal_count = (tcw == 1);
    for (int b = 0; b < 2000 && !done; b++) begin
      @(negedge clock);
      if (hold_request) hcyc++;
      if (!started && dma_acknowledge_internal != 4'b0000) begin started = 1'b1; cyc = 0; end
      else cyc++;
      if (next_word) begin nw++; cyc = 0; end
      if (end_of_process_internal) eops++;
      dack_seen |= dma_acknowledge_internal;
      if ((dma_acknowledge_internal != 4'b0000) != address_enable) aen_bad++;
      if (!memory_read_n)  lo_mr++;
      if (!memory_write_n) lo_mw++;
      if (!io_read_n)      lo_ir++;
      if (!io_write_n)     lo_iw++;
      if (started && !hold_request) done = 1'b1;
      if (hcyc > hd) hold_acknowledge = 1'b1;
      if (hold_request) encoded_dma = 4'($urandom_range(1, 15));
      w = 0;
      if (nw < 4) w = int'(wv[2*nw +: 2]);
      // Each CPU clock after the word anchor is 4 system clocks; S3 first samples ready at +12.
      ready = !started || (cyc >= 11 + 4*w);
      terminal_count = (nw + 1 == tcw);
      dma_request_state[ch] = dem ? (nw < reqw) : 1'b1;
      end_of_process_n = !(started && cyc == 6 && nw + 1 == eopw);
    end
    check("svc_done", 32'(done), 32'd1);

    exp_w = 1;
    if (dem) begin
      exp_w = tcw;
      if (eopw < exp_w) exp_w = eopw;
      if (reqw < exp_w) exp_w = reqw;
    end
    exp_eop = (exp_w == tcw || exp_w == eopw) ? 1 : 0;
    exp_rd = 0; exp_wr = 0;
    for (int i = 0; i < exp_w; i++) begin
      w = int'(wv[2*i +: 2]);
      exp_rd += 10 + 4*w;
`ifdef KF8237_EXTENDED_WRITE_EN
      exp_wr += 10 + 4*w;
`else
      exp_wr += 6 + 4*w;
`endif
    end
    check("svc_words", 32'(nw), 32'(exp_w));
    check("svc_eop", 32'(eops), 32'(exp_eop));
    check("svc_dack", 32'(dack_seen), 32'(4'b0001 << ch));
    check("svc_aen", 32'(aen_bad), 32'd0);
    check("svc_mem_rd_lo", 32'(lo_mr), 32'(ty == 2 ? exp_rd : 0));
    check("svc_mem_wr_lo", 32'(lo_mw), 32'(ty == 1 ? exp_wr : 0));
    check("svc_io_rd_lo",  32'(lo_ir), 32'(ty == 1 ? exp_rd : 0));
    check("svc_io_wr_lo",  32'(lo_iw), 32'(ty == 2 ? exp_wr : 0));
    check("svc_rotate", 32'(dma_rotate), 32'(ch));
    check("svc_release", 32'({dma_acknowledge_internal, address_enable}), 32'd0);

    // HLDA still high: fresh grants must not raise HRQ.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      encoded_dma = 4'($urandom_range(1, 15));
      if (hold_request) hrq_ign++;
    end
    check("grant_ignored_hlda", 32'(hrq_ign), 32'd0);
    encoded_dma = 4'b0000; hold_acknowledge = 1'b0; ready = 1'b1;
    end_of_process_n = 1'b1; terminal_count = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic reset_mid(input int ch, input int ty, input bit use_mc, input string tag);
    bit got;
    got = 1'b0;
    mode_transfer_type[2*ch +: 2] = 2'(ty);
    mode_demand = 4'b0000;
    dma_request_state = 4'b1111;
    encoded_dma = 4'b0001 << ch;
    ready = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (hold_request) hold_acknowledge = 1'b1;
      if (!(memory_write_n & io_write_n)) got = 1'b1;
    end
    check({tag, "_reach"}, 32'(got), 32'd1);
    apply_clear(use_mc, tag);
    repeat (4) @(negedge clock);
  endtask

  initial begin
    logic [3:0] dack_any;
    repeat (4) @(negedge clock);
    apply_clear(1'b0, "reset_state");
    repeat (4) @(negedge clock);

    run_service(2, 2, 1'b0, 4, 5, 5, 1, 8'h00);
    run_service(0, 1, 1'b1, 3, 5, 5, 2, 8'h00);
    run_service(2, 2, 1'b0, 4, 5, 5, 0, 8'h02);
    run_service(1, 2, 1'b1, 4, 2, 5, 0, 8'h00);
    run_service(3, 3, 1'b1, 2, 5, 5, 0, 8'h00);

    apply_clear(1'b0, "reset_before_drop");
    mode_demand = 4'b0000;
    dma_request_state = 4'b0010;
    encoded_dma = 4'b0010;
    for (int i = 0; i < 40 && !hold_request; i++) @(negedge clock);
    check("drop_hrq_up", 32'(hold_request), 32'd1);
    dma_request_state = 4'b0000;
    encoded_dma = 4'b0000;
    dack_any = 4'b0000;
    for (int i = 0; i < 40 && hold_request; i++) begin
      @(negedge clock);
      dack_any |= dma_acknowledge_internal;
    end
    check("drop_hrq_down", 32'(hold_request), 32'd0);
    check("drop_no_dack", 32'(dack_any), 32'd0);
    check("drop_rotate", 32'(dma_rotate), 32'd3);
    repeat (8) @(negedge clock);

    reset_mid(3, 1, 1'b0, "reset_in_s3");
    reset_mid(1, 2, 1'b1, "mclear_in_s3");

    for (int k = 0; k < 24; k++)
      run_service($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 4), $urandom_range(1, 5), $urandom_range(1, 5),
                  $urandom_range(0, 5), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
